noise_table_loader: RTL
=======================

Name: noise_table_loader

Overview:
- Runtime writer for the 4096x8 blue-noise table that the dithering datapath reads.
- Accepts a byte stream from the host/config path over valid/ready and writes it sequentially to table addresses 0..4095.
- Writes only during vertical blanking, because the dither reader occupies both BRAM ports during active video.
- Drives the write side of the BRAM port mux and a table_valid flag that the dither path uses to bypass noise while the table is incomplete.

Parameters:
- ABITS, 12, table address width; table depth is 2**ABITS bytes.
- INIT_VALID, 1, reset value of table_valid. Set to 1 when the BRAM is preloaded from noise.mem.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a table load
- abort  in  1  one-cycle pulse that cancels a load in progress
- vblank  in  1  high while the display is in vertical blanking
- s_data  in  8  noise byte, two's complement
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts a byte this cycle
- mem_sel  out  1  loader owns BRAM port A (port mux select)
- mem_we  out  1  BRAM write enable
- mem_addr  out  ABITS  BRAM write address
- mem_wdata  out  8  BRAM write data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when a load completes
- table_valid  out  1  table contents are complete and usable
- chk_err  out  1  sticky checksum mismatch (see Optional Feature)

Behaviour:
- Reset values: s_ready=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, chk_err=0, table_valid=INIT_VALID. Reset mid-load returns to IDLE; BRAM contents are left partial and table_valid takes INIT_VALID.
- States:
  - IDLE: start -> LOAD. Entering LOAD sets addr counter=0, clears table_valid and chk_err.
  - LOAD: a byte is accepted on the cycle s_valid && s_ready.
  - CHECK (checksum build only): entered after the last table byte.
  - DONE: one cycle; asserts done, sets table_valid, then -> IDLE.
- s_ready = (state==LOAD) && vblank. It is combinational, so it drops in the same cycle vblank falls. The load pauses with no data loss and resumes on the next vblank.
- Write latency is 1 cycle. The cycle after a handshake: mem_we=1, mem_addr=counter, mem_wdata=accepted byte. The counter increments with each write.
- mem_sel = (LOAD && vblank) || mem_we. It covers a write issued in the cycle after vblank falls; the dither output is blanked in that cycle anyway.
- Counter wrap: the handshake at counter 2**ABITS-1 writes the final byte. Next state is DONE, or CHECK with the feature enabled. The counter wraps to 0 and no further bytes are accepted.
- start while busy: ignored.
- abort in any non-IDLE state: -> IDLE on the next cycle, table_valid stays 0, no done pulse.
  - A write already registered still completes.
  - abort and a handshake in the same cycle: abort wins and the byte is dropped (no write).
- start and abort in the same IDLE cycle: abort wins and the loader stays IDLE.
- s_valid outside LOAD: ignored; s_ready stays 0.

Optional Feature:
- Macro: NOISE_LOAD_CHECKSUM_EN.
- Defined:
  - A 16-bit modular sum of all table bytes (unsigned) accumulates during LOAD.
  - After the last table byte, state CHECK accepts 2 more bytes (low byte first, same s_ready rule) and compares them to the sum.
  - Mismatch: chk_err=1, table_valid stays 0, done still pulses.
  - Match: table_valid=1.
- Undefined: no CHECK state, chk_err is tied to 0, and the load completes after 2**ABITS bytes.

Decomposition:
- Shared package (noise_pkg): table depth/ABITS constant, state encoding typedef, checksum width constant.
- The state machine and counter stay in one module.
- One sub-module is natural: noise_checksum16 (accumulator plus compare), instantiated only under NOISE_LOAD_CHECKSUM_EN.

Test Plan:
- vblank=1, start, then 4096 bytes with s_valid held high, data=addr[7:0] -> 4096 mem_we pulses, addr 0..4095 in order, wdata matches, done one cycle after the last write, table_valid=1.
- Drop vblank at byte 1000 for 50 cycles -> s_ready=0 that same cycle, no writes during the gap, addr resumes at 1000 (or 1001 if that byte was already accepted), total write count still 4096.
- abort at byte 200, concurrent with a handshake -> byte 200 not written, IDLE next cycle, table_valid=0, no done; a subsequent start restarts at addr 0.
- start while busy at byte 10 -> counter unaffected; rst at byte 300 -> all outputs at reset values, table_valid=INIT_VALID.
- Checksum build: all bytes 0x01 then trailer 0x00,0x10 -> table_valid=1, chk_err=0; trailer 0x01,0x10 -> chk_err=1, table_valid=0, done still pulses.
- s_valid pulsed in IDLE with vblank=1 -> s_ready=0, mem_we never asserted, mem_sel=0.

Source files
------------

// File: rtl/noise_pkg.sv
// Shared constants and state encoding for the blue-noise table loader.
package noise_pkg;

  localparam int unsigned NOISE_ABITS = 12;
  localparam int unsigned CHK_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/noise_checksum16.sv
// 16-bit modular sum of table bytes plus a two-byte trailer compare (low byte first).
module noise_checksum16
  import noise_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic       trl_i,
  input  logic [7:0] data_i,
  output logic       last_o,
  output logic       match_o
);

  logic [CHK_W-1:0] sum_q;
  logic [7:0]       lo_q;
  logic             seen_lo_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sum_q     <= '0;
      lo_q      <= '0;
      seen_lo_q <= 1'b0;
    end else begin
      if (add_i) sum_q <= sum_q + CHK_W'(data_i);
      if (trl_i) begin
        lo_q      <= data_i;
        seen_lo_q <= !seen_lo_q;
      end
    end
  end

  // Valid on the cycle the high trailer byte is presented.
  assign last_o  = seen_lo_q;
  assign match_o = ({data_i, lo_q} == sum_q);

endmodule

// File: rtl/noise_table_loader.sv
// Streams 2**ABITS noise bytes into the dither BRAM during vblank only.
// Optional trailer checksum: define NOISE_LOAD_CHECKSUM_EN.
module noise_table_loader
  import noise_pkg::*;
#(
  parameter int unsigned ABITS      = NOISE_ABITS,
  parameter bit          INIT_VALID = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             vblank,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             mem_sel,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             table_valid,
  output logic             chk_err
);

  localparam logic [ABITS-1:0] CNT_LAST = {ABITS{1'b1}};

  state_e           state_q;
  logic [ABITS-1:0] cnt_q;
  logic [ABITS-1:0] addr_q;
  logic [7:0]       wdata_q;
  logic             we_q;
  logic             done_q;
  logic             tv_q;

  logic in_load, in_chk, hs, start_load;
  logic chk_last, done_ok;

  assign in_load    = (state_q == ST_LOAD);
  assign in_chk     = (state_q == ST_CHECK);
  // NOTE: s_ready is combinational so it drops in the very cycle vblank falls;
  // registering it would let one byte slip through after blanking ends.
  assign s_ready    = (in_load || in_chk) && vblank;
  assign hs         = s_valid && s_ready && !abort;  // abort drops a concurrent byte
  assign start_load = (state_q == ST_IDLE) && start && !abort;

`ifdef NOISE_LOAD_CHECKSUM_EN
  localparam state_e ST_AFTER_LOAD = ST_CHECK;

  logic chk_match;
  logic chk_err_q;
  logic chk_ok_q;

  noise_checksum16 u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start_load),
    .add_i  (hs && in_load),
    .trl_i  (hs && in_chk),
    .data_i (s_data),
    .last_o (chk_last),
    .match_o(chk_match)
  );

  always_ff @(posedge clk) begin
    if (rst || start_load) begin
      chk_err_q <= 1'b0;
      chk_ok_q  <= 1'b0;
    end else if (hs && in_chk && chk_last) begin
      chk_err_q <= !chk_match;
      chk_ok_q  <= chk_match;
    end
  end

  assign chk_err = chk_err_q;
  assign done_ok = chk_ok_q;
`else
  localparam state_e ST_AFTER_LOAD = ST_DONE;

  assign chk_last = 1'b0;
  assign chk_err  = 1'b0;
  assign done_ok  = 1'b1;
`endif

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of cnt_q/state_q regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      tv_q    <= INIT_VALID;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_load) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            tv_q    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (hs) begin
            we_q    <= 1'b1;
            addr_q  <= cnt_q;
            wdata_q <= s_data;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= ST_AFTER_LOAD;
          end
        end
        ST_CHECK: begin
          if (abort)                state_q <= ST_IDLE;
          else if (hs && chk_last)  state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (!abort) begin
            done_q <= 1'b1;
            tv_q   <= done_ok;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A write registered just before vblank falls still owns the port for its cycle.
  assign mem_sel     = (in_load && vblank) || we_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign table_valid = tv_q;

endmodule
